mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 38 +++
 rtl/mc_ctrl_if.sv | 31 +++
 rtl/rv32i_opdec.sv | 27 ++
 rtl/mc_ctrl.sv | 90 +++++++++
 tb/tb_mc_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM.
package mc_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_IJ = 7'b1100111;
   localparam logic [6:0] OP_IL = 7'b0000011;
   localparam logic [6:0] OP_SB = 7'b1100011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_UJ = 7'b1101111;
   localparam logic [6:0] OP_U  = 7'b0110111;
   localparam logic [6:0] OP_UI = 7'b0010111;
   localparam logic [6:0] OP_R  = 7'b0110011;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef struct packed {
      logic i;
      logic ij;
      logic il;
      logic sb;
      logic s;
      logic uj;
      logic u;
      logic ui;
   } imm_sel_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> memory/datapath bus; master is the controller side.
interface mc_ctrl_if;
   logic [31:0] instr;
   logic        imem_ack;
   logic        dmem_ack;
   logic        br_taken;
   logic        imem_req;
   logic        ir_we;
   logic        I_imm, Ij_imm, Il_imm, SB_imm, S_imm, UJ_imm, U_imm, Ui_imm;
   logic        dmem_req;
   logic        dmem_we;
   logic        rf_we;
   logic        pc_we;
   logic [1:0]  pc_sel;
   logic [31:0] instret;
   logic        trap;

   modport master (
      input  instr, imem_ack, dmem_ack, br_taken,
      output imem_req, ir_we,
      output I_imm, Ij_imm, Il_imm, SB_imm, S_imm, UJ_imm, U_imm, Ui_imm,
      output dmem_req, dmem_we, rf_we, pc_we, pc_sel, instret, trap
   );

   modport slave (
      output instr, imem_ack, dmem_ack, br_taken,
      input  imem_req, ir_we,
      input  I_imm, Ij_imm, Il_imm, SB_imm, S_imm, UJ_imm, U_imm, Ui_imm,
      input  dmem_req, dmem_we, rf_we, pc_we, pc_sel, instret, trap
   );
endinterface

// File: rtl/rv32i_opdec.sv
// Combinational opcode decoder: one-hot immediate-format select plus illegal flag.
module rv32i_opdec
   import mc_pkg::*;
(
   input  logic [6:0] opcode,
   output imm_sel_t   sel,
   output logic       illegal
);

   always_comb begin
      sel     = '0;
      illegal = 1'b0;
      case (opcode)
         OP_I:    sel.i  = 1'b1;
         OP_IJ:   sel.ij = 1'b1;
         OP_IL:   sel.il = 1'b1;
         OP_SB:   sel.sb = 1'b1;
         OP_S:    sel.s  = 1'b1;
         OP_UJ:   sel.uj = 1'b1;
         OP_U:    sel.u  = 1'b1;
         OP_UI:   sel.ui = 1'b1;
         OP_R:    ;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP on
// illegal opcodes and a retired-instruction counter.
module mc_ctrl
   import mc_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   mc_ctrl_if.master bus
);

   state_t      state, state_nxt;
   logic [6:0]  opcode_q;
   imm_sel_t    dec_sel, sel_q, sel_out;
   logic        dec_illegal;
   logic [1:0]  pc_sel_q;
   logic [31:0] instret_q;

   rv32i_opdec u_opdec (
      .opcode  (opcode_q),
      .sel     (dec_sel),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   if (bus.imem_ack) state_nxt = DECODE;
         DECODE:  state_nxt = dec_illegal ? TRAP : EXEC;
         EXEC:    state_nxt = (sel_q.il || sel_q.s) ? MEM : WB;
         MEM:     if (bus.dmem_ack) state_nxt = WB;
         WB:      state_nxt = FETCH;
         TRAP:    state_nxt = TRAP;
         default: state_nxt = FETCH;
      endcase
   end

   // Select and pc_sel are cleared in WB so they read zero once FETCH is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode_q  <= '0;
         sel_q     <= '0;
         pc_sel_q  <= PC_SEQ;
         instret_q <= '0;
      end else begin
         case (state)
            FETCH:  if (bus.imem_ack) opcode_q <= bus.instr[6:0];
            DECODE: sel_q <= dec_sel;
            EXEC: begin
               if (sel_q.sb)                pc_sel_q <= bus.br_taken ? PC_BR : PC_SEQ;
               else if (sel_q.uj || sel_q.ij) pc_sel_q <= PC_JMP;
               else                         pc_sel_q <= PC_SEQ;
            end
            WB: begin
               instret_q <= instret_q + 32'd1;
               sel_q     <= '0;
               pc_sel_q  <= PC_SEQ;
            end
            default: ;
         endcase
      end
   end

   // The decoder drives the selects directly during DECODE; the register takes over after.
   assign sel_out = (state == DECODE) ? dec_sel : sel_q;

   assign bus.I_imm  = sel_out.i;
   assign bus.Ij_imm = sel_out.ij;
   assign bus.Il_imm = sel_out.il;
   assign bus.SB_imm = sel_out.sb;
   assign bus.S_imm  = sel_out.s;
   assign bus.UJ_imm = sel_out.uj;
   assign bus.U_imm  = sel_out.u;
   assign bus.Ui_imm = sel_out.ui;

   assign bus.imem_req = (state == FETCH);
   assign bus.ir_we    = (state == FETCH) && bus.imem_ack;
   assign bus.dmem_req = (state == MEM);
   assign bus.dmem_we  = (state == MEM) && sel_q.s;
   assign bus.pc_we    = (state == WB);
   assign bus.rf_we    = (state == WB) && !(sel_q.sb || sel_q.s);
   assign bus.pc_sel   = pc_sel_q;
   assign bus.instret  = instret_q;
   assign bus.trap     = (state == TRAP);

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus randomized instruction stream.
module tb_mc_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mc_ctrl_if bus ();

   mc_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_ret = '0;

   // strobe vector order: imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap
   localparam logic [6:0] ST_FETCH  = 7'b1000000;
   localparam logic [6:0] ST_ACK    = 7'b1100000;
   localparam logic [6:0] ST_NONE   = 7'b0000000;
   localparam logic [6:0] ST_TRAP   = 7'b0000001;

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   function automatic logic [31:0] rw();
      return $urandom;
   endfunction

   // select vector order: I, Ij, Il, SB, S, UJ, U, Ui
   function automatic logic [7:0] ref_sel(input logic [6:0] op);
      case (op)
         7'b0010011: return 8'b1000_0000;
         7'b1100111: return 8'b0100_0000;
         7'b0000011: return 8'b0010_0000;
         7'b1100011: return 8'b0001_0000;
         7'b0100011: return 8'b0000_1000;
         7'b1101111: return 8'b0000_0100;
         7'b0110111: return 8'b0000_0010;
         7'b0010111: return 8'b0000_0001;
         default:    return 8'b0000_0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [31:0] ins, input logic ia, input logic da, input logic bt,
                      input logic [6:0] es, input logic [7:0] esel, input string tag);
      @(negedge clk);
      bus.instr    = ins;
      bus.imem_ack = ia;
      bus.dmem_ack = da;
      bus.br_taken = bt;
      #1;
      check({tag, "_strb"}, {25'b0, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
                             bus.rf_we, bus.pc_we, bus.trap}, {25'b0, es});
      check({tag, "_sel"}, {24'b0, bus.I_imm, bus.Ij_imm, bus.Il_imm, bus.SB_imm, bus.S_imm,
                            bus.UJ_imm, bus.U_imm, bus.Ui_imm}, {24'b0, esel});
      check({tag, "_instret"}, bus.instret, exp_ret);
   endtask

   // One legal instruction end to end: fw fetch wait cycles, mw data wait cycles.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic bt);
      logic [7:0] s;
      logic       is_mem, is_st, no_rf;
      logic [1:0] exp_ps;
      s      = ref_sel(ins[6:0]);
      is_mem = s[5] | s[3];
      is_st  = s[3];
      no_rf  = s[4] | s[3];
      exp_ps = s[4] ? {1'b0, bt} : ((s[6] | s[2]) ? 2'b10 : 2'b00);
      for (int i = 0; i < fw; i++) cyc(rw(), 1'b0, rb(), rb(), ST_FETCH, 8'h00, "fetch_wait");
      cyc(ins, 1'b1, rb(), rb(), ST_ACK, 8'h00, "fetch");
      cyc(rw(), rb(), rb(), rb(), ST_NONE, s, "decode");
      cyc(rw(), rb(), rb(), bt, ST_NONE, s, "exec");
      if (is_mem)
         for (int i = 0; i <= mw; i++)
            cyc(rw(), rb(), (i == mw), rb(), {2'b00, 1'b1, is_st, 3'b000}, s, "mem");
      cyc(rw(), rb(), rb(), rb(), {4'b0000, ~no_rf, 1'b1, 1'b0}, s, "wb");
      check("wb_pc_sel", {30'b0, bus.pc_sel}, {30'b0, exp_ps});
      exp_ret = exp_ret + 32'd1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      rst = 1'b1;
      #1;
      exp_ret = '0;
      check({tag, "_strb"}, {25'b0, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
                             bus.rf_we, bus.pc_we, bus.trap}, {25'b0, ST_FETCH});
      check({tag, "_sel"}, {24'b0, bus.I_imm, bus.Ij_imm, bus.Il_imm, bus.SB_imm, bus.S_imm,
                            bus.UJ_imm, bus.U_imm, bus.Ui_imm}, 32'h0);
      check({tag, "_pc_sel"}, {30'b0, bus.pc_sel}, 32'h0);
      check({tag, "_instret"}, bus.instret, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check({tag, "_post_imem_req"}, {31'b0, bus.imem_req}, 32'h1);
   endtask

   task automatic run_trap(input logic [31:0] ins);
      cyc(ins, 1'b1, rb(), rb(), ST_ACK, 8'h00, "trap_fetch");
      cyc(rw(), rb(), rb(), rb(), ST_NONE, 8'h00, "trap_decode");
      for (int i = 0; i < 12; i++)
         cyc(rw(), logic'(i % 2), rb(), rb(), ST_TRAP, 8'h00, "trap_hold");
      do_reset("trap_reset");
   endtask

   logic [6:0] legal_ops [9] = '{7'b0010011, 7'b1100111, 7'b0000011, 7'b1100011, 7'b0100011,
                                 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};

   initial begin
      logic [31:0] r;
      bus.instr    = '0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      bus.br_taken = 1'b0;

      do_reset("reset");

      run_instr(32'h00500093, 0, 0, 1'b0);   // ADDI
      run_instr(32'h0000A103, 0, 2, 1'b0);   // LW, ack late
      run_instr(32'h00208463, 0, 0, 1'b1);   // BEQ taken
      run_instr(32'h00208463, 0, 0, 1'b0);   // BEQ not taken
      run_instr(32'h0000006F, 1, 0, 1'b0);   // JAL
      run_instr(32'h00008067, 0, 0, 1'b1);   // JALR
      run_instr(32'h123450B7, 2, 0, 1'b0);   // LUI
      run_instr(32'h00001097, 0, 0, 1'b0);   // AUIPC
      run_instr(32'h002081B3, 0, 0, 1'b1);   // ADD
      run_instr(32'h00112023, 0, 1, 1'b0);   // SW

      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         run_instr({r[31:7], legal_ops[$urandom_range(0, 8)]},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb());
      end

      // reset in the middle of a store's MEM phase
      cyc(32'h00112023, 1'b1, 1'b0, 1'b0, ST_ACK, 8'h00, "sw_fetch");
      cyc(rw(), 1'b0, 1'b0, 1'b0, ST_NONE, 8'h08, "sw_decode");
      cyc(rw(), 1'b0, 1'b0, 1'b0, ST_NONE, 8'h08, "sw_exec");
      cyc(rw(), 1'b0, 1'b0, 1'b0, 7'b0011000, 8'h08, "sw_mem");
      do_reset("mid_mem_reset");

      run_trap(32'h00000000);
      run_trap(32'h00000073);
      run_instr(32'h00500093, 0, 0, 1'b0);

      // wrap of the retired-instruction counter
      @(negedge clk);
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      exp_ret = 32'hFFFF_FFFF;
      run_instr(32'h00500093, 0, 0, 1'b0);
      check("instret_wrap", exp_ret, 32'h0);
      run_instr(32'h002081B3, 0, 0, 1'b0);
      @(negedge clk);
      #1;
      check("instret_after_wrap", bus.instret, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
